mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the core's instruction-fetch port (IF stage) and data port (MEM stage).
- Uses a per-cycle req/gnt handshake with data-side priority.
- A starvation counter guarantees fetch progress during long data streams.
- A fetch-flush input discards the stale instruction response on a branch redirect.

Parameters:
- DATA_WIDTH, 32, width of the data buses.
- ADDR_WIDTH, 12, word address width of the shared SRAM.
- MAX_DATA_STREAK, 4, maximum consecutive data grants while a fetch is waiting (legal range ≥1).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_inst_req  in  1  fetch request
- i_inst_addr  in  ADDR_WIDTH  fetch address
- i_inst_flush  in  1  discard the fetch response due this cycle
- o_inst_gnt  out  1  fetch accepted this cycle
- o_inst_rvalid  out  1  fetch data valid
- o_inst_rdata  out  DATA_WIDTH  fetch data
- i_data_req  in  1  data request
- i_data_we  in  1  1 = write, 0 = read
- i_data_be  in  DATA_WIDTH/8  byte enables (writes only)
- i_data_addr  in  ADDR_WIDTH  data address
- i_data_wdata  in  DATA_WIDTH  write data
- o_data_gnt  out  1  data request accepted
- o_data_rvalid  out  1  load data valid
- o_data_rdata  out  DATA_WIDTH  load data
- o_mem_en  out  1  SRAM enable
- o_mem_we  out  1  SRAM write enable
- o_mem_be  out  DATA_WIDTH/8  SRAM byte enables
- o_mem_addr  out  ADDR_WIDTH  SRAM address
- o_mem_wdata  out  DATA_WIDTH  SRAM write data
- i_mem_rdata  in  DATA_WIDTH  SRAM read data, valid 1 cycle after an enabled read

Behaviour:
- Reset (asynchronous, active-high): response state RSP_NONE; streak counter 0.
  - All o_*rvalid outputs are 0 while i_rst is high.
  - gnt and o_mem_* are combinational and follow the arbitration rules below.
- Handshake:
  - A transfer occurs in the cycle where req && gnt.
  - At most one grant per cycle; a requester holds req and its signals stable until granted.
  - A new grant is allowed every cycle (fully pipelined).
- Arbitration, evaluated combinationally each cycle:
  - Only data requests: grant data.
  - Only fetch requests: grant fetch.
  - Both, and streak < MAX_DATA_STREAK: grant data.
  - Both, and streak == MAX_DATA_STREAK: grant fetch.
- Streak counter, registered:
  - Increments (saturating at MAX_DATA_STREAK) on each data grant while i_inst_req is high.
  - Clears to 0 on a fetch grant, or in any cycle where i_inst_req is low.
- SRAM drive:
  - o_mem_en = any grant.
  - o_mem_we = data grant && i_data_we.
  - addr/be/wdata are muxed from the granted port.
  - be is forced to all-ones for fetches.
  - When idle, all o_mem_* outputs are 0.
- Response state machine, registered, one response in flight max:
  - RSP_NONE → RSP_INST on a fetch grant.
  - RSP_NONE → RSP_DATA on a data read grant.
  - A data write grant goes to RSP_NONE; writes produce no rvalid.
  - From any state, the next state is determined solely by this cycle's grant.
- Read latency is exactly 1 cycle after grant:
  - o_inst_rvalid = (state == RSP_INST) && !i_inst_flush.
  - o_data_rvalid = (state == RSP_DATA).
  - Both rdata outputs = i_mem_rdata, driven unconditionally; consumers qualify with rvalid.
- Flush:
  - Suppresses only the fetch response presented in that same cycle.
  - A fetch request in the flush cycle is arbitrated normally; its response appears next cycle.
- Reset mid-read: the in-flight response is dropped and no rvalid is issued after reset is released.
- Simultaneous write data + fetch: the same priority rules apply; the write consumes the SRAM cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - enum rsp_sel_e {RSP_NONE, RSP_INST, RSP_DATA};
  - constant BE_WIDTH = DATA_WIDTH/8.
- Single module; the arbitration logic and streak counter are too small to justify a sub-module.

Test Plan:
- Fetch-only stream (addrs 0x000, 0x001, 0x002, back-to-back):
  - o_inst_gnt is high in all 3 cycles.
  - o_inst_rvalid is high in the following 3 cycles with the SRAM words preloaded at those addresses.
- Data write then read:
  - Write 0xDEADBEEF, be=4'b1111 to 0x010; o_data_gnt=1 and no rvalid.
  - Next cycle, read 0x010; one cycle later o_data_rvalid=1 and rdata=0xDEADBEEF.
- Partial write:
  - Preload 0x020 = 0x11223344, then write 0xAABBCCDD with be=4'b0011.
  - A subsequent read of 0x020 returns 0x1122CCDD.
- Starvation, MAX_DATA_STREAK=4:
  - Hold i_inst_req and i_data_req high continuously.
  - Grants follow D, D, D, D, I, D, D, D, D, I…; the streak clears after each fetch grant.
- Flush:
  - Fetch 0x030 is granted in cycle N; i_inst_flush=1 in cycle N+1 with a new fetch of 0x100.
  - o_inst_rvalid=0 in N+1; in N+2, o_inst_rvalid=1 with mem[0x100].
- Reset mid-read:
  - Data read granted in cycle N; i_rst asserted asynchronously before the N+1 edge.
  - o_data_rvalid stays 0; after release, state is RSP_NONE and streak is 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the core's memory-side blocks: response selector for the
// single-port SRAM arbiter and the default byte-enable width.
package riscv_pkg;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_INST = 2'd1,
    RSP_DATA = 2'd2
  } rsp_sel_e;

  localparam int PKG_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = PKG_DATA_WIDTH / 8;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and the data port,
// with data priority bounded by a starvation counter and fetch-flush support.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH      = PKG_DATA_WIDTH,
  parameter int ADDR_WIDTH      = 12,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_inst_req,
  input  logic [ADDR_WIDTH-1:0]   i_inst_addr,
  input  logic                    i_inst_flush,
  output logic                    o_inst_gnt,
  output logic                    o_inst_rvalid,
  output logic [DATA_WIDTH-1:0]   o_inst_rdata,
  input  logic                    i_data_req,
  input  logic                    i_data_we,
  input  logic [DATA_WIDTH/8-1:0] i_data_be,
  input  logic [ADDR_WIDTH-1:0]   i_data_addr,
  input  logic [DATA_WIDTH-1:0]   i_data_wdata,
  output logic                    o_data_gnt,
  output logic                    o_data_rvalid,
  output logic [DATA_WIDTH-1:0]   o_data_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [DATA_WIDTH/8-1:0] o_mem_be,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_nxt;
  rsp_sel_e            r_rsp;
  rsp_sel_e            w_rsp_nxt;
  logic                w_inst_gnt;
  logic                w_data_gnt;

  // Data wins unless a fetch has already waited out a full data streak.
  always_comb begin
    w_data_gnt = i_data_req && (!i_inst_req || (r_streak < STREAK_MAX));
    w_inst_gnt = i_inst_req && !w_data_gnt;
  end

  always_comb begin
    w_streak_nxt = r_streak;
    if (!i_inst_req || w_inst_gnt) begin
      w_streak_nxt = '0;
    end else if (w_data_gnt && (r_streak < STREAK_MAX)) begin
      w_streak_nxt = r_streak + STREAK_W'(1);
    end
  end

  always_comb begin
    w_rsp_nxt = RSP_NONE;
    if (w_inst_gnt) begin
      w_rsp_nxt = RSP_INST;
    end else if (w_data_gnt && !i_data_we) begin
      w_rsp_nxt = RSP_DATA;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp    <= RSP_NONE;
      r_streak <= '0;
    end else begin
      r_rsp    <= w_rsp_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Idle cycles drive the SRAM bus to all zeros.
  always_comb begin
    o_mem_en    = w_inst_gnt || w_data_gnt;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_data_gnt) begin
      o_mem_we    = i_data_we;
      o_mem_be    = i_data_be;
      o_mem_addr  = i_data_addr;
      o_mem_wdata = i_data_wdata;
    end else if (w_inst_gnt) begin
      o_mem_be    = {BE_W{1'b1}};
      o_mem_addr  = i_inst_addr;
    end
  end

  assign o_inst_gnt    = w_inst_gnt;
  assign o_data_gnt    = w_data_gnt;
  assign o_inst_rvalid = (r_rsp == RSP_INST) && !i_inst_flush;
  assign o_data_rvalid = (r_rsp == RSP_DATA);
  assign o_inst_rdata  = i_mem_rdata;
  assign o_data_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus pushes expected read data,
// a negedge monitor pops and compares whenever an rvalid is presented.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int DW = 32;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              instReq = 1'b0;
  logic [AW-1:0]     instAddr = '0;
  logic              instFlush = 1'b0;
  logic              instGnt, instRvalid;
  logic [DW-1:0]     instRdata;
  logic              dataReq = 1'b0;
  logic              dataWe = 1'b0;
  logic [BE_WIDTH-1:0] dataBe = '0;
  logic [AW-1:0]     dataAddr = '0;
  logic [DW-1:0]     dataWdata = '0;
  logic              dataGnt, dataRvalid;
  logic [DW-1:0]     dataRdata;
  logic              memEn, memWe;
  logic [BE_WIDTH-1:0] memBe;
  logic [AW-1:0]     memAddr;
  logic [DW-1:0]     memWdata;
  logic [DW-1:0]     memRdata;

  logic [DW-1:0]     sram [0:(1<<AW)-1];
  logic              doPreload = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] expInst[$];
  logic [DW-1:0] expData[$];

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_DATA_STREAK(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(instReq), .i_inst_addr(instAddr), .i_inst_flush(instFlush),
    .o_inst_gnt(instGnt), .o_inst_rvalid(instRvalid), .o_inst_rdata(instRdata),
    .i_data_req(dataReq), .i_data_we(dataWe), .i_data_be(dataBe),
    .i_data_addr(dataAddr), .i_data_wdata(dataWdata),
    .o_data_gnt(dataGnt), .o_data_rvalid(dataRvalid), .o_data_rdata(dataRdata),
    .o_mem_en(memEn), .o_mem_we(memWe), .o_mem_be(memBe),
    .o_mem_addr(memAddr), .o_mem_wdata(memWdata), .i_mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM with byte-enabled writes and 1-cycle reads.
  always @(posedge clk) begin
    if (doPreload) begin
      sram[12'h000] <= 32'h0000_A000;
      sram[12'h001] <= 32'h0000_A001;
      sram[12'h002] <= 32'h0000_A002;
      sram[12'h020] <= 32'h1122_3344;
      sram[12'h030] <= 32'h0000_3030;
      sram[12'h040] <= 32'h4040_4040;
      sram[12'h050] <= 32'h5050_5050;
      sram[12'h100] <= 32'hCAFE_0100;
    end else if (memEn) begin
      if (memWe) begin
        for (int b = 0; b < BE_WIDTH; b++)
          if (memBe[b]) sram[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
      end else begin
        memRdata <= sram[memAddr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Response monitor: every presented rvalid must match the oldest expectation.
  always @(negedge clk) begin
    if (instRvalid === 1'b1) begin
      if (expInst.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL inst_rsp: got unexpected rvalid data 0x%08h expected none at %0t", instRdata, $time);
      end else begin
        checkOutput("inst_rdata", instRdata, expInst.pop_front());
      end
    end
    if (dataRvalid === 1'b1) begin
      if (expData.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL data_rsp: got unexpected rvalid data 0x%08h expected none at %0t", dataRdata, $time);
      end else begin
        checkOutput("data_rdata", dataRdata, expData.pop_front());
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle of requests; grants and SRAM drive are checked at the negedge,
  // expected read data is queued just after so the monitor never sees it early.
  task automatic applyStimulus(
    input logic iReq, input logic [AW-1:0] iAddr, input logic flush,
    input logic dReq, input logic dWe, input logic [BE_WIDTH-1:0] dBe,
    input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata,
    input logic expIGnt, input logic expDGnt,
    input logic pushI, input logic [DW-1:0] valI,
    input logic pushD, input logic [DW-1:0] valD);
    logic [AW-1:0] eAddr;
    logic [BE_WIDTH-1:0] eBe;
    logic [DW-1:0] eWdata;
    instReq = iReq; instAddr = iAddr; instFlush = flush;
    dataReq = dReq; dataWe = dWe; dataBe = dBe; dataAddr = dAddr; dataWdata = dWdata;
    eAddr = expDGnt ? dAddr : (expIGnt ? iAddr : '0);
    eBe = expDGnt ? dBe : (expIGnt ? {BE_WIDTH{1'b1}} : '0);
    eWdata = expDGnt ? dWdata : '0;
    @(negedge clk);
    checkOutput("inst_gnt", instGnt, expIGnt);
    checkOutput("data_gnt", dataGnt, expDGnt);
    checkOutput("mem_en", memEn, expIGnt | expDGnt);
    checkOutput("mem_we", memWe, expDGnt & dWe);
    checkOutput("mem_addr", memAddr, eAddr);
    checkOutput("mem_be", memBe, eBe);
    checkOutput("mem_wdata", memWdata, eWdata);
    #1;
    if (pushI) expInst.push_back(valI);
    if (pushD) expData.push_back(valD);
  endtask

  task automatic idleCycle();
    applyStimulus(0, '0, 0, 0, 0, '0, '0, '0, 0, 0, 0, '0, 0, '0);
    nextCycle();
  endtask

  // Both requesters active: fetch 0x050, data read 0x040.
  task automatic bothCycle(input logic expD, input logic pushRsp);
    applyStimulus(1, 12'h050, 0, 1, 0, 4'hF, 12'h040, '0, !expD, expD,
                  pushRsp && !expD, 32'h5050_5050, pushRsp && expD, 32'h4040_4040);
  endtask

  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    doPreload = 1'b0;
    @(posedge clk); @(negedge clk);
    checkOutput("reset_inst_rvalid", instRvalid, 0);
    checkOutput("reset_data_rvalid", dataRvalid, 0);
    checkOutput("reset_mem_en", memEn, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back fetches of 0x000..0x002.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, AW'(i), 0, 0, 0, '0, '0, '0, 1, 0, 1, 32'h0000_A000 + DW'(i), 0, '0);
      nextCycle();
    end
    idleCycle();

    // Full write then read-back.
    applyStimulus(0, '0, 0, 1, 1, 4'hF, 12'h010, 32'hDEAD_BEEF, 0, 1, 0, '0, 0, '0);
    nextCycle();
    applyStimulus(0, '0, 0, 1, 0, 4'hF, 12'h010, '0, 0, 1, 0, '0, 1, 32'hDEAD_BEEF);
    nextCycle();
    idleCycle();

    // Partial write over a preloaded word.
    applyStimulus(0, '0, 0, 1, 1, 4'b0011, 12'h020, 32'hAABB_CCDD, 0, 1, 0, '0, 0, '0);
    nextCycle();
    applyStimulus(0, '0, 0, 1, 0, 4'hF, 12'h020, '0, 0, 1, 0, '0, 1, 32'h1122_CCDD);
    nextCycle();
    idleCycle();

    // Starvation pattern D D D D I D D D D I.
    for (int i = 0; i < 10; i++) begin
      bothCycle((i % 5) != 4, 1);
      nextCycle();
    end
    idleCycle();

    // Flush: response to 0x030 is discarded, the 0x100 fetch in the flush cycle lands next.
    applyStimulus(1, 12'h030, 0, 0, 0, '0, '0, '0, 1, 0, 0, '0, 0, '0);
    nextCycle();
    applyStimulus(1, 12'h100, 1, 0, 0, '0, '0, '0, 1, 0, 1, 32'hCAFE_0100, 0, '0);
    checkOutput("flush_inst_rvalid", instRvalid, 0);
    nextCycle();
    idleCycle();

    // Reset while a data read is in flight, with the streak part-way up.
    idleCycle();
    bothCycle(1, 1);
    nextCycle();
    bothCycle(1, 1);
    nextCycle();
    bothCycle(1, 0);
    #2;
    rst = 1'b1;
    instReq = 0; dataReq = 0; dataWe = 0; dataBe = '0; dataAddr = '0; instAddr = '0;
    #1;
    checkOutput("rst_async_data_rvalid", dataRvalid, 0);
    nextCycle();
    checkOutput("rst_held_data_rvalid", dataRvalid, 0);
    checkOutput("rst_held_inst_rvalid", instRvalid, 0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_data_rvalid", dataRvalid, 0);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      bothCycle(i != 4, 1);
      nextCycle();
    end
    idleCycle();
    idleCycle();

    checkOutput("inst_pending", DW'(expInst.size()), 0);
    checkOutput("data_pending", DW'(expData.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
